// File: rtl/rob_writeback_commit_pkg.sv
// Shared types for the writeback/commit stage: the ROB entry layout and index-width helper.
package rob_writeback_commit_pkg;

  localparam int REG_ADDR_BITS = 5;

  typedef struct packed {
    logic [31:0]              pc;
    logic [REG_ADDR_BITS-1:0] waddr;
    logic [31:0]              wdata;
    logic                     wen;
  } rob_entry_t;

  // A single-requester arbiter still needs a 1-bit index so ports stay legal.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_writeback_commit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a rotating priority pointer.
module rr_arbiter
  import rob_writeback_commit_pkg::*;
#(
  parameter int p_num_reqs = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [p_num_reqs-1:0]             req,
  output logic [p_num_reqs-1:0]             gnt,
  output logic                              gnt_val,
  output logic [idx_bits(p_num_reqs)-1:0]   gnt_idx
);

  localparam int PTR_W = idx_bits(p_num_reqs);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_val = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = (int'(ptr_q) + k) % p_num_reqs;
      if (!rst && !gnt_val && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_val  = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_val) ptr_d = PTR_W'((int'(gnt_idx) + 1) % p_num_reqs);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rob_writeback_commit.sv
// Writeback arbitration across N execute pipes into a reorder buffer, with in-order commit.
module rob_writeback_commit
  import rob_writeback_commit_pkg::*;
#(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_num_pipes-1:0]              ex_val,
  output logic [p_num_pipes-1:0]              ex_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] ex_seq_num,
  input  logic [p_num_pipes*32-1:0]           ex_pc,
  input  logic [p_num_pipes*REG_ADDR_BITS-1:0] ex_waddr,
  input  logic [p_num_pipes*32-1:0]           ex_wdata,
  input  logic [p_num_pipes-1:0]              ex_wen,
  output logic                                complete_val,
  output logic [p_seq_num_bits-1:0]           complete_seq_num,
  output logic [REG_ADDR_BITS-1:0]            complete_waddr,
  output logic [31:0]                         complete_wdata,
  output logic                                complete_wen,
  output logic                                commit_val,
  output logic [p_seq_num_bits-1:0]           commit_seq_num,
  output logic [31:0]                         commit_pc,
  output logic [REG_ADDR_BITS-1:0]            commit_waddr,
  output logic [31:0]                         commit_wdata,
  output logic                                commit_wen
);

  localparam int DEPTH  = 2**p_seq_num_bits;
  localparam int PIPE_W = idx_bits(p_num_pipes);

  logic              gnt_val;
  logic [PIPE_W-1:0] gnt_idx;

  rr_arbiter #(.p_num_reqs(p_num_pipes)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (ex_val),
    .gnt     (ex_rdy),
    .gnt_val (gnt_val),
    .gnt_idx (gnt_idx)
  );

  rob_entry_t                wb_entry;
  logic [p_seq_num_bits-1:0] wb_seq;

  always_comb begin
    wb_seq         = ex_seq_num[gnt_idx*p_seq_num_bits +: p_seq_num_bits];
    wb_entry.pc    = ex_pc[gnt_idx*32 +: 32];
    wb_entry.waddr = ex_waddr[gnt_idx*REG_ADDR_BITS +: REG_ADDR_BITS];
    wb_entry.wdata = ex_wdata[gnt_idx*32 +: 32];
    wb_entry.wen   = ex_wen[gnt_idx];
  end

  assign complete_val     = gnt_val;
  assign complete_seq_num = wb_seq;
  assign complete_waddr   = wb_entry.waddr;
  assign complete_wdata   = wb_entry.wdata;
  assign complete_wen     = wb_entry.wen;

  rob_entry_t                rob_q [DEPTH];
  rob_entry_t                rob_d [DEPTH];
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [p_seq_num_bits-1:0] head_q, head_d;

  // Commit reads registered state only, so a fresh writeback is visible one cycle later.
  assign commit_val     = valid_q[head_q] & ~rst;
  assign commit_seq_num = head_q;
  assign commit_pc      = rob_q[head_q].pc;
  assign commit_waddr   = rob_q[head_q].waddr;
  assign commit_wdata   = rob_q[head_q].wdata;
  assign commit_wen     = rob_q[head_q].wen;

  always_comb begin
    rob_d   = rob_q;
    valid_d = valid_q;
    head_d  = head_q;
    if (commit_val) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (gnt_val) begin
      rob_d[wb_seq]   = wb_entry;
      valid_d[wb_seq] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  // Payload storage needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    rob_q <= rob_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && gnt_val)
      assert (!valid_q[wb_seq])
        else $error("writeback to occupied ROB entry %0d", wb_seq);
  end

  function automatic string line_trace();
    return $sformatf("wb %s%0d:%08h | cm %s%0d:%08h",
                     complete_val ? "*" : " ", complete_seq_num, complete_wdata,
                     commit_val   ? "*" : " ", commit_seq_num,   commit_wdata);
  endfunction
`endif

endmodule

// File: tb/tb_rob_writeback_commit.sv
// Randomized and directed bench for rob_writeback_commit against an absolute-sequence reference model.
module tb_rob_writeback_commit;
  import rob_writeback_commit_pkg::*;

  localparam int NP    = 3;
  localparam int SB    = 3;
  localparam int DEPTH = 2**SB;

  logic                        clk, rst;
  logic [NP-1:0]               ex_val, ex_rdy, ex_wen;
  logic [NP*SB-1:0]            ex_seq_num;
  logic [NP*32-1:0]            ex_pc, ex_wdata;
  logic [NP*REG_ADDR_BITS-1:0] ex_waddr;
  logic                        complete_val, complete_wen, commit_val, commit_wen;
  logic [SB-1:0]               complete_seq_num, commit_seq_num;
  logic [REG_ADDR_BITS-1:0]    complete_waddr, commit_waddr;
  logic [31:0]                 complete_wdata, commit_pc, commit_wdata;

  rob_writeback_commit #(.p_num_pipes(NP), .p_seq_num_bits(SB)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_val           (ex_val),
    .ex_rdy           (ex_rdy),
    .ex_seq_num       (ex_seq_num),
    .ex_pc            (ex_pc),
    .ex_waddr         (ex_waddr),
    .ex_wdata         (ex_wdata),
    .ex_wen           (ex_wen),
    .complete_val     (complete_val),
    .complete_seq_num (complete_seq_num),
    .complete_waddr   (complete_waddr),
    .complete_wdata   (complete_wdata),
    .complete_wen     (complete_wen),
    .commit_val       (commit_val),
    .commit_seq_num   (commit_seq_num),
    .commit_pc        (commit_pc),
    .commit_waddr     (commit_waddr),
    .commit_wdata     (commit_wdata),
    .commit_wen       (commit_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: results keyed by absolute (unwrapped) sequence number;
  // commits proceed by absolute number, and the wire sequence is that number mod DEPTH.
  rob_entry_t done_m [int];
  int         commit_abs_m = 0;
  int         rr_m         = 0;
  int         alloc_abs    = 0;
  int         pool [$];

  bit         p_val [NP];
  int         p_abs [NP];
  rob_entry_t p_ent [NP];

  task automatic drive_pipes();
    for (int i = 0; i < NP; i++) begin
      ex_val[i]                                 = p_val[i];
      ex_seq_num[i*SB +: SB]                    = SB'(p_abs[i] % DEPTH);
      ex_pc[i*32 +: 32]                         = p_ent[i].pc;
      ex_waddr[i*REG_ADDR_BITS +: REG_ADDR_BITS] = p_ent[i].waddr;
      ex_wdata[i*32 +: 32]                      = p_ent[i].wdata;
      ex_wen[i]                                 = p_ent[i].wen;
    end
  endtask

  task automatic place(input int pipe, input int abs_seq, input logic [31:0] wdata, input logic wen);
    p_val[pipe]       = 1'b1;
    p_abs[pipe]       = abs_seq;
    p_ent[pipe].pc    = $urandom;
    p_ent[pipe].waddr = REG_ADDR_BITS'($urandom_range(0, 31));
    p_ent[pipe].wdata = wdata;
    p_ent[pipe].wen   = wen;
  endtask

  task automatic step();
    int            g;
    int            hs;
    logic          cv;
    logic [NP-1:0] exp_rdy;
    rob_entry_t    e;
    drive_pipes();
    @(negedge clk);
    g       = -1;
    exp_rdy = '0;
    if (!rst)
      for (int k = 0; k < NP; k++)
        if (g < 0 && p_val[(rr_m + k) % NP]) g = (rr_m + k) % NP;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ex_rdy", 32'(ex_rdy), 32'(exp_rdy));
    chk("complete_val", 32'(complete_val), 32'(g >= 0));
    if (g >= 0) begin
      chk("complete_seq", 32'(complete_seq_num), 32'(p_abs[g] % DEPTH));
      chk("complete_waddr", 32'(complete_waddr), 32'(p_ent[g].waddr));
      chk("complete_wdata", complete_wdata, p_ent[g].wdata);
      chk("complete_wen", 32'(complete_wen), 32'(p_ent[g].wen));
    end
    hs = commit_abs_m;
    cv = !rst && done_m.exists(hs);
    chk("commit_val", 32'(commit_val), 32'(cv));
    if (cv) begin
      e = done_m[hs];
      chk("commit_seq", 32'(commit_seq_num), 32'(hs % DEPTH));
      chk("commit_pc", commit_pc, e.pc);
      chk("commit_waddr", 32'(commit_waddr), 32'(e.waddr));
      chk("commit_wdata", commit_wdata, e.wdata);
      chk("commit_wen", 32'(commit_wen), 32'(e.wen));
    end
    if (rst) begin
      done_m.delete();
      commit_abs_m = 0;
      rr_m         = 0;
    end else begin
      if (cv) begin
        done_m.delete(hs);
        commit_abs_m++;
      end
      if (g >= 0) begin
        done_m[p_abs[g]] = p_ent[g];
        rr_m             = (g + 1) % NP;
        p_val[g]         = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input bit allow_alloc);
    while (allow_alloc && alloc_abs < commit_abs_m + DEPTH && $urandom_range(0, 2) != 0) begin
      pool.push_back(alloc_abs);
      alloc_abs++;
    end
    for (int i = 0; i < NP; i++) begin
      if (!p_val[i] && pool.size() > 0 && $urandom_range(0, 3) != 0) begin
        int j;
        j = $urandom_range(0, pool.size() - 1);
        place(i, pool[j], $urandom, $urandom_range(0, 3) != 0);
        pool.delete(j);
      end
    end
  endtask

  function automatic bit idle();
    bit busy;
    busy = pool.size() > 0 || commit_abs_m != alloc_abs;
    for (int i = 0; i < NP; i++) busy |= p_val[i];
    return !busy;
  endfunction

  initial begin
    int c;
    int cyc;
    rst = 1'b1;
    for (int i = 0; i < NP; i++) begin
      p_val[i] = 1'b0;
      p_abs[i] = 0;
      p_ent[i] = '0;
    end
    step();
    step();
    rst = 1'b0;
    step();

    // in-order on a single pipe
    place(0, 0, 32'hA, 1'b1); step();
    place(0, 1, 32'hB, 1'b1); step();
    place(0, 2, 32'hC, 1'b1); step();
    step(); step();

    // out-of-order completion: younger first, head arrives two cycles later
    place(1, 4, 32'h11, 1'b1); step();
    step();
    place(0, 3, 32'h10, 1'b1); step();
    step(); step(); step();

    // all pipes requesting continuously; grants must rotate
    alloc_abs = commit_abs_m;
    c = alloc_abs;
    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < NP; i++)
        if (!p_val[i] && alloc_abs < c + 9) begin
          place(i, alloc_abs, $urandom, 1'b1);
          alloc_abs++;
        end
      step();
    end

    // write-enable clear still commits and advances the head
    c = commit_abs_m;
    place(2, c, 32'h5, 1'b0); step();
    step(); step();

    // reset with younger entries pending and the head missing
    c = commit_abs_m;
    place(0, c + 2, 32'h22, 1'b1);
    place(1, c + 3, 32'h33, 1'b1);
    step(); step(); step();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) p_val[i] = 1'b0;
    step();
    rst = 1'b0;
    step(); step();
    place(0, 0, 32'h77, 1'b1); step();
    step(); step(); step();

    // randomized out-of-order traffic across many head wraps
    alloc_abs = commit_abs_m;
    pool.delete();
    for (int n = 0; n < 600; n++) begin
      refill(1'b1);
      step();
    end
    cyc = 0;
    while (!idle() && cyc < 300) begin
      refill(1'b0);
      step();
      cyc++;
    end
    if (!idle()) chk("drain_timeout", 32'(commit_abs_m), 32'(alloc_abs));
    step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/rob_writeback_commit.md
Name: rob_writeback_commit

Overview:
- Parametrised successor to the fixed two-pipe writeback/commit stage.
- Accepts completed instructions from N execute pipes, out of order, and arbitrates one writeback per cycle with round-robin fairness.
- Publishes a completion notification for scoreboard and bypass use.
- Holds results in a reorder buffer indexed by sequence number and commits strictly in program order, one per cycle, on the commit notification.

Parameters:
- p_num_pipes, 2, number of execute pipes feeding writeback (1..8).
- p_seq_num_bits, 5, width of sequence number; ROB depth = 2**p_seq_num_bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_val  in  p_num_pipes  per-pipe result valid
- ex_rdy  out  p_num_pipes  per-pipe accept (grant)
- ex_seq_num  in  p_num_pipes*p_seq_num_bits  per-pipe sequence number
- ex_pc  in  p_num_pipes*32  per-pipe PC
- ex_waddr  in  p_num_pipes*5  per-pipe destination register
- ex_wdata  in  p_num_pipes*32  per-pipe result
- ex_wen  in  p_num_pipes  per-pipe register-write enable
- complete_val  out  1  writeback this cycle
- complete_seq_num  out  p_seq_num_bits  sequence number written back
- complete_waddr  out  5  destination register
- complete_wdata  out  32  result
- complete_wen  out  1  register-write enable
- commit_val  out  1  in-order commit this cycle
- commit_seq_num  out  p_seq_num_bits  committed sequence number
- commit_pc  out  32  committed PC
- commit_waddr  out  5  committed destination
- commit_wdata  out  32  committed data
- commit_wen  out  1  committed write enable

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset clears all ROB valid bits, head pointer = 0, and round-robin priority pointer = 0.
- While rst is high, ex_rdy = 0, complete_val = 0 and commit_val = 0. All data outputs are don't-care when their val is 0.

Arbitration (combinational):
- Scan ex_val starting at the priority pointer, wrapping modulo p_num_pipes. The first valid pipe i gets ex_rdy[i] = 1; all others get 0.
- On a grant to pipe i, the pointer becomes (i+1) mod p_num_pipes at the clock edge.
- No grant leaves the pointer unchanged.
- ex_rdy depends on ex_val. Upstream pipes must hold val and payload stable until rdy.

Writeback (same cycle as grant):
- complete_* mirrors the granted pipe's payload; complete_val = 1 when any pipe is granted.
- At the edge, write pc/waddr/wdata/wen into rob[seq_num] and set valid[seq_num].

Commit (combinational from ROB head):
- commit_val = valid[head], and commit_* = rob[head] fields.
- When commit_val is 1, at the edge clear valid[head] and set head = head+1 (wraps at 2**p_seq_num_bits).

Latency and boundaries:
- Minimum latency from writeback to commit is 1 cycle; there is no writeback-to-commit bypass.
- If the head entry is written back in cycle N, it commits in cycle N+1.
- Head wrap: after seq 2**p_seq_num_bits-1, commit continues with seq 0.
- Simultaneous writeback to entry X and commit of head H != X: both take effect in the same edge.
- Writeback to X == H while valid[H] = 1 is illegal.
- ROB full/empty: decode guarantees at most 2**p_seq_num_bits in flight, so writeback never stalls for ROB space.
- Writeback to an entry whose valid bit is already set is an error; a non-synthesis assertion flags it.
- Reset mid-operation discards all pending entries. No commit occurs in the reset cycle or the cycle it deasserts, unless a writeback was made after deassertion.

Decomposition:
- Shared package: the ROB entry typedef (pc, waddr, wdata, wen) and the register-address width constant of 5.
- Sub-module rr_arbiter (p_num_reqs): round-robin grant vector plus priority-pointer state. Reusable by the decode/issue unit.
- Line-trace function for the completion and commit streams, non-synthesis only.

Test Plan:
- In-order single pipe: pipe0 seq 0,1,2, wdata 0xA,0xB,0xC, wen = 1 on consecutive cycles -> complete on the same cycles; commit seq 0,1,2 one cycle later each, wdata matches.
- Out-of-order completion: seq 1 (pipe1, wdata 0x11) written back in cycle 0, then seq 0 (pipe0, wdata 0x10) in cycle 2 -> no commit in cycles 1-2; commit seq 0 in cycle 3, seq 1 in cycle 4.
- Arbitration fairness: both pipes val continuously with distinct seqs -> grants alternate pipe0, pipe1, pipe0, …; the ungranted pipe holds; all 8 seqs commit in order.
- Wrap-around (p_seq_num_bits = 3): 20 in-order results -> commit_seq_num runs 0..7,0..7,0..3 with no gaps.
- wen = 0 entry: seq 0 with wen = 0 -> commit_val = 1 with commit_wen = 0; head advances.
- Reset mid-stream: entries for seq 2 and 3 written back, head at 0 (seq 0 missing), assert rst one cycle -> commit_val stays 0. After reset, a writeback of seq 0 commits seq 0 only.
